dram_feature_sorter: RTL and testbench

//   Upstream stage of the FSRAM/IR-SRAM write controller. Takes raw row-major feature-map pixels

---
 rtl/dram_feature_sorter.sv | 155 +++++++++++++++
 tb/tb_dram_feature_sorter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dram_feature_sorter.sv
// Reorders row-major DRAM pixels into write-controller order: rows 0/1 column-interleaved,
// then rows 2..ROW-1 serpentine. A two-row ping-pong buffer lets loading overlap emission.
module dram_feature_sorter #(
    parameter int ROW    = 6,
    parameter int COL    = 6,
    parameter int CH_IN  = 4,
    parameter int CH_OUT = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                dram_valid,
    output logic                dram_ready,
    input  logic [CH_IN*8-1:0]  dram_data,
    output logic                out_valid,
    output logic [CH_OUT*8-1:0] out_data,
    output logic                busy,
    output logic                done
);
    localparam int PW  = CH_IN * 8;
    localparam int PAD = (CH_OUT - CH_IN) * 8;
    localparam int CW  = (COL > 1) ? $clog2(COL) : 1;
    localparam int RW  = $clog2(ROW + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);
    localparam logic [RW-1:0] ROW_END  = RW'(ROW);

    typedef enum logic [2:0] {S_IDLE, S_LOAD01, S_EMIT01, S_STREAM, S_DONE} state_t;

    state_t        state;
    logic [PW-1:0] mem [2][COL];
    logic [1:0]    full;
    logic [RW-1:0] wr_row, rd_row;
    logic [CW-1:0] wr_col, rd_col;
    logic          rd_sel;

    logic          accept, wr_last;
    logic          emit_p0, buf_p0;
    logic [CW-1:0] col_p0;
    logic [PW-1:0] pix_p0;

    assign dram_ready = (state inside {S_LOAD01, S_EMIT01, S_STREAM})
                        && !full[wr_row[0]] && (wr_row < ROW_END);
    assign accept     = dram_valid && dram_ready;
    assign wr_last    = accept && (wr_col == COL_LAST);

    // Stage p0: pick the pixel scheduled for emission this cycle.
    always_comb begin
        emit_p0 = 1'b0;
        buf_p0  = 1'b0;
        col_p0  = rd_col;
        if (state == S_EMIT01) begin
            emit_p0 = 1'b1;
            buf_p0  = rd_sel;
        end else if (state == S_STREAM) begin
            emit_p0 = full[rd_row[0]];
            buf_p0  = rd_row[0];
            col_p0  = rd_row[0] ? rd_col : (COL_LAST - rd_col);
        end
    end

    assign pix_p0 = mem[buf_p0][col_p0];

    // Buffer storage carries no reset; the full flags qualify its contents.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_row[0]][wr_col] <= dram_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            full      <= 2'b00;
            wr_row    <= '0;
            wr_col    <= '0;
            rd_row    <= '0;
            rd_col    <= '0;
            rd_sel    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Stage p1: registered output beat.
            out_valid <= emit_p0;
            out_data  <= emit_p0 ? {{PAD{1'b0}}, pix_p0} : '0;
            done      <= 1'b0;

            if (accept) begin
                if (wr_col == COL_LAST) begin
                    wr_col <= '0;
                    wr_row <= wr_row + 1'b1;
                end else begin
                    wr_col <= wr_col + 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD01;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD01: begin
                    rd_sel <= 1'b0;
                    rd_col <= '0;
                    if (wr_last && wr_row == RW'(1))
                        state <= S_EMIT01;
                end
                S_EMIT01: begin
                    rd_sel <= ~rd_sel;
                    if (rd_sel) begin
                        if (rd_col == COL_LAST) begin
                            rd_col <= '0;
                            rd_row <= RW'(2);
                            full   <= 2'b00;
                            state  <= S_STREAM;
                        end else begin
                            rd_col <= rd_col + 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (emit_p0) begin
                        if (rd_col == COL_LAST) begin
                            rd_col           <= '0;
                            rd_row           <= rd_row + 1'b1;
                            full[rd_row[0]]  <= 1'b0;
                            if (rd_row == ROW_LAST)
                                state <= S_DONE;
                        end else begin
                            rd_col <= rd_col + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                    wr_row <= '0;
                    wr_col <= '0;
                    rd_row <= '0;
                    rd_col <= '0;
                    rd_sel <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase

            // A buffer is only filled while empty, so this never collides with a free above.
            if (wr_last)
                full[wr_row[0]] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dram_feature_sorter.sv
// Bench for dram_feature_sorter: directed and randomized tiles checked against an
// order model built from the row/column emission rules.
module tb_dram_feature_sorter;
    localparam int ROW = 6, COL = 6, CH_IN = 4, CH_OUT = 32;
    localparam int PW = CH_IN * 8, OW = CH_OUT * 8, N = ROW * COL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          dram_valid = 1'b0;
    logic          dram_ready, out_valid, busy, done;
    logic [PW-1:0] dram_data = '0;
    logic [OW-1:0] out_data;

    dram_feature_sorter #(.ROW(ROW), .COL(COL), .CH_IN(CH_IN), .CH_OUT(CH_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dram_valid(dram_valid),
        .dram_ready(dram_ready), .dram_data(dram_data), .out_valid(out_valid),
        .out_data(out_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [PW-1:0] pix [N];
    logic [PW-1:0] expq[$];
    logic [PW-1:0] got[$];
    int send_idx, limit, mode, cyc, done_cnt, upper_bad, zero_bad, row_gap;
    int low_run, low_max, last_beat_cyc, done_cyc, busy_at_done;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkp(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Fill the pixel table and derive the expected emission order from the ordering rules.
    task automatic new_tile(input bit rnd);
        logic [3:0] r4, c4;
        for (int i = 0; i < N; i++) begin
            r4 = 4'(i / COL);
            c4 = 4'(i % COL);
            pix[i] = rnd ? PW'($urandom) : {4{r4, c4}};
        end
        expq.delete();
        for (int c = 0; c < COL; c++) begin
            expq.push_back(pix[c]);
            expq.push_back(pix[COL + c]);
        end
        for (int r = 2; r < ROW; r++)
            for (int k = 0; k < COL; k++)
                expq.push_back(pix[r * COL + ((r % 2 == 1) ? k : COL - 1 - k)]);
        got.delete();
        send_idx = 0; limit = N; done_cnt = 0; upper_bad = 0; zero_bad = 0;
        row_gap = 0; low_run = 0; low_max = 0; last_beat_cyc = -1; done_cyc = -1;
        busy_at_done = -1;
    endtask

    // One clock: observe outputs at the falling edge, then drive the next DRAM beat.
    task automatic step();
        bit v;
        @(negedge clk);
        cyc++;
        if (out_valid) begin
            got.push_back(out_data[PW-1:0]);
            last_beat_cyc = cyc;
            if (out_data[OW-1:PW] != '0) upper_bad++;
        end else begin
            if (out_data != '0) zero_bad++;
            if (got.size() % COL != 0) row_gap++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = int'(busy);
        end
        if (mode == 0 && busy && got.size() >= 2 * COL && send_idx < limit && !dram_ready)
            low_run++;
        else
            low_run = 0;
        if (low_run > low_max) low_max = low_run;
        case (mode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = ($urandom_range(0, 3) != 0);
        endcase
        dram_valid = v && (send_idx < limit);
        dram_data  = dram_valid ? pix[send_idx] : PW'($urandom);
        if (dram_valid && dram_ready) send_idx++;
    endtask

    task automatic do_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            step();
            k++;
        end
        chk({tag, " done within budget"}, int'(done_cnt != 0), 1);
    endtask

    task automatic check_tile(input string tag);
        chk({tag, " beat count"}, got.size(), N);
        for (int i = 0; i < N && i < got.size(); i++)
            chkp($sformatf("%s beat%0d", tag, i), got[i], expq[i]);
        chk({tag, " done pulses"}, done_cnt, 1);
        chk({tag, " done follows last beat"}, done_cyc - last_beat_cyc, 1);
        chk({tag, " busy low with done"}, busy_at_done, 0);
        chk({tag, " upper bytes zero"}, upper_bad, 0);
        chk({tag, " idle data zero"}, zero_bad, 0);
    endtask

    initial begin
        mode = 0; cyc = 0;
        new_tile(0);
        limit = 0;
        repeat (2) @(negedge clk);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_data zero", int'(out_data != '0), 0);
        chk("reset dram_ready", int'(dram_ready), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        rst_n = 1'b1;

        // Reset asserted while rows 0/1 are being emitted.
        new_tile(0);
        do_start();
        for (int k = 0; k < 100 && got.size() < 3; k++) step();
        chk("t1 reached emit phase", int'(got.size() >= 3), 1);
        rst_n = 1'b0;
        #1;
        chk("t1 out_valid in reset", int'(out_valid), 0);
        chk("t1 out_data in reset", int'(out_data != '0), 0);
        chk("t1 busy in reset", int'(busy), 0);
        chk("t1 dram_ready in reset", int'(dram_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        new_tile(0);
        limit = 0;
        repeat (5) step();
        chk("t1 no residual beats", got.size(), 0);
        chk("t1 idle after reset", int'(busy), 0);
        new_tile(0);
        do_start();
        run_until_done("t1", 400);
        check_tile("t1");

        // Continuous input, reference pixel pattern.
        new_tile(0);
        do_start();
        run_until_done("t2", 400);
        check_tile("t2");
        chk("t3 ready-low run bounded", int'(low_max <= COL), 1);

        // Input valid toggling every cycle.
        mode = 1;
        new_tile(0);
        do_start();
        run_until_done("t4", 600);
        check_tile("t4");
        chk("t4 no gap inside a row", row_gap, 0);

        // Start pulsed while busy, then a start right after done.
        mode = 0;
        new_tile(1);
        do_start();
        repeat (5) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        start = 1'b1;
        step();
        start = 1'b0;
        run_until_done("t5", 400);
        check_tile("t5");
        new_tile(1);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5 restart busy", int'(busy), 1);
        run_until_done("t5b", 400);
        check_tile("t5b");

        // Input stalls after row 3, then resumes.
        new_tile(1);
        limit = 4 * COL;
        do_start();
        repeat (80) step();
        chk("t6 rows 0-3 drained", got.size(), 4 * COL);
        chk("t6 busy during stall", int'(busy), 1);
        chk("t6 no output during stall", int'(out_valid), 0);
        chk("t6 no done during stall", done_cnt, 0);
        limit = N;
        run_until_done("t6", 400);
        check_tile("t6");

        // Randomized input-valid pattern with random pixels.
        mode = 2;
        for (int t = 0; t < 3; t++) begin
            new_tile(1);
            do_start();
            run_until_done($sformatf("rnd%0d", t), 1000);
            check_tile($sformatf("rnd%0d", t));
        end
        repeat (4) step();
        chk("final no extra done", done_cnt, 1);
        chk("final no extra beats", got.size(), N);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
